synapse_table: RTL and testbench

Parametrised synaptic weight store for the neuron array. It maps a presynaptic neuron number to a stored weight through a fully associative tag table of DEPTH entries. It serves weight lookups over a valid/ready handshake with a registered response, and applies signed STDP weight updates by read-modify-write. It sits between the spike router (lookups), the learning unit (STDP deltas) and the host configuration path (entry programming).

---
 rtl/synapse_table.sv | 154 +++++++++++++++
 tb/tb_synapse_table.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_table.sv
// Associative neuron->weight store: 1-cycle registered lookup over valid/ready, STDP read-modify-write.
// rd_ready drops only while a response is held unconsumed; SYNAPSE_SAT_EN clamps STDP results and adds sat_seen.
module synapse_table #(
  parameter int NEURON_W = 7,
  parameter int WEIGHT_W = 8,
  parameter int DEPTH    = 16,
  parameter int DELTA_W  = 4,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic                cfg_valid,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [NEURON_W-1:0] cfg_tag,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [NEURON_W-1:0] rd_neuron,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_hit,
  output logic [WEIGHT_W-1:0] out_weight,
  input  logic                stdp_valid,
  input  logic [NEURON_W-1:0] stdp_neuron,
  input  logic [DELTA_W-1:0]  stdp_delta,
  output logic                stdp_miss
`ifdef SYNAPSE_SAT_EN
  ,
  output logic                sat_seen
`endif
);

  typedef struct packed {
    logic                vld;
    logic [NEURON_W-1:0] tag;
    logic [WEIGHT_W-1:0] wt;
  } entry_t;

  entry_t tbl_q [DEPTH];

  logic                rd_hit, st_hit;
  logic [IDX_W-1:0]    rd_idx, st_idx;
  logic                cfg_ok, rd_acc, stdp_apply;
  logic [WEIGHT_W-1:0] st_new;

  logic                out_valid_q, out_valid_d;
  logic                out_hit_q, out_hit_d;
  logic [WEIGHT_W-1:0] out_weight_q, out_weight_d;
  logic                stdp_miss_q, stdp_miss_d;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    st_hit = 1'b0;
    st_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl_q[i].vld && tbl_q[i].tag == rd_neuron) begin
        rd_hit = 1'b1;
        rd_idx = IDX_W'(i);
      end
      if (tbl_q[i].vld && tbl_q[i].tag == stdp_neuron) begin
        st_hit = 1'b1;
        st_idx = IDX_W'(i);
      end
    end
  end

`ifdef SYNAPSE_SAT_EN
  localparam int SUM_W = WEIGHT_W + 2;
  logic [SUM_W-1:0] st_sum;
  logic             st_clamp;
  logic             sat_seen_q;

  always_comb begin
    st_sum   = {2'b00, tbl_q[st_idx].wt}
             + {{(SUM_W - DELTA_W){stdp_delta[DELTA_W-1]}}, stdp_delta};
    st_clamp = 1'b1;
    if (st_sum[SUM_W-1])       st_new = '0;
    else if (st_sum[WEIGHT_W]) st_new = '1;
    else begin
      st_new   = st_sum[WEIGHT_W-1:0];
      st_clamp = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || kill)                 sat_seen_q <= 1'b0;
    else if (stdp_apply && st_clamp) sat_seen_q <= 1'b1;
  end

  assign sat_seen = sat_seen_q;
`else
  // Wrapping result: bits above WEIGHT_W would be dropped, so add at native width.
  assign st_new = tbl_q[st_idx].wt
                + {{(WEIGHT_W - DELTA_W){stdp_delta[DELTA_W-1]}}, stdp_delta};
`endif

  assign cfg_ok     = cfg_valid && (32'(cfg_idx) < DEPTH);
  assign stdp_apply = stdp_valid && st_hit && !kill && !(cfg_ok && cfg_idx == st_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill)
          tbl_q[i].vld <= 1'b0;
        else if (cfg_ok && cfg_idx == IDX_W'(i))
          tbl_q[i] <= {1'b1, cfg_tag, cfg_weight};
        else if (stdp_apply && st_idx == IDX_W'(i))
          tbl_q[i].wt <= st_new;
      end
    end
  end

  assign rd_ready = !out_valid_q || out_ready;
  assign rd_acc   = rd_valid && rd_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_hit_d    = out_hit_q;
    out_weight_d = out_weight_q;
    if (rd_acc) begin
      out_valid_d  = 1'b1;
      out_hit_d    = rd_hit;
      out_weight_d = rd_hit ? tbl_q[rd_idx].wt : '0;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
    stdp_miss_d = stdp_valid && !stdp_apply;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_weight_q <= '0;
      stdp_miss_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_weight_q <= out_weight_d;
      stdp_miss_q  <= stdp_miss_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_weight = out_weight_q;
  assign stdp_miss  = stdp_miss_q;

endmodule

// File: tb/tb_synapse_table.sv
// Bench for synapse_table: directed vectors with literal expectations plus a table model checked every cycle.
module tb_synapse_table;
  localparam int NEURON_W = 7;
  localparam int WEIGHT_W = 8;
  localparam int DEPTH    = 16;
  localparam int DELTA_W  = 4;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int WMAX     = (1 << WEIGHT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                kill = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [IDX_W-1:0]    cfg_idx = '0;
  logic [NEURON_W-1:0] cfg_tag = '0;
  logic [WEIGHT_W-1:0] cfg_weight = '0;
  logic                rd_valid = 1'b0;
  logic                rd_ready;
  logic [NEURON_W-1:0] rd_neuron = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                out_hit;
  logic [WEIGHT_W-1:0] out_weight;
  logic                stdp_valid = 1'b0;
  logic [NEURON_W-1:0] stdp_neuron = '0;
  logic [DELTA_W-1:0]  stdp_delta = '0;
  logic                stdp_miss;
`ifdef SYNAPSE_SAT_EN
  logic                sat_seen;
`endif

  int checks = 0;
  int errors = 0;

  synapse_table #(.NEURON_W(NEURON_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .DELTA_W(DELTA_W)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_tag(cfg_tag), .cfg_weight(cfg_weight),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_neuron(rd_neuron),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_weight(out_weight),
    .stdp_valid(stdp_valid), .stdp_neuron(stdp_neuron), .stdp_delta(stdp_delta),
    .stdp_miss(stdp_miss)
`ifdef SYNAPSE_SAT_EN
    , .sat_seen(sat_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: plain arrays, first-match search, integer weight arithmetic.
  bit m_vld [DEPTH];
  int m_tag [DEPTH];
  int m_wt  [DEPTH];
  bit e_vld, e_hit, e_miss, e_sat, live;
  int e_wt;
  bit f_hit, s_hit, disc;
  int f_idx, s_idx, s_val;

  function automatic void find(input int key, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && m_tag[i] == key) begin
        hit = 1'b1;
        idx = i;
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_vld[i] = 1'b0; m_tag[i] = 0; m_wt[i] = 0;
      end
      e_vld = 1'b0; e_hit = 1'b0; e_wt = 0; e_miss = 1'b0; e_sat = 1'b0;
    end else begin
      if (rd_valid && (!e_vld || out_ready)) begin
        find(int'(rd_neuron), f_hit, f_idx);
        e_vld = 1'b1;
        e_hit = f_hit;
        e_wt  = f_hit ? m_wt[f_idx] : 0;
      end else if (out_ready) begin
        e_vld = 1'b0;
      end
      find(int'(stdp_neuron), s_hit, s_idx);
      disc   = !s_hit || kill || (cfg_valid && int'(cfg_idx) == s_idx);
      e_miss = stdp_valid && disc;
      if (stdp_valid && !disc) begin
        s_val = m_wt[s_idx] + int'($signed(stdp_delta));
`ifdef SYNAPSE_SAT_EN
        if (s_val < 0)         begin s_val = 0;    e_sat = 1'b1; end
        else if (s_val > WMAX) begin s_val = WMAX; e_sat = 1'b1; end
`else
        s_val = s_val & WMAX;
`endif
        m_wt[s_idx] = s_val;
      end
      if (cfg_valid && !kill && int'(cfg_idx) < DEPTH) begin
        m_vld[cfg_idx] = 1'b1;
        m_tag[cfg_idx] = int'(cfg_tag);
        m_wt[cfg_idx]  = int'(cfg_weight);
      end
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        e_sat = 1'b0;
      end
    end
    live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_out_valid", out_valid, e_vld);
      chk("model_rd_ready", rd_ready, (!e_vld || out_ready));
      chk("model_stdp_miss", stdp_miss, e_miss);
      if (e_vld) begin
        chk("model_out_hit", out_hit, e_hit);
        chk("model_out_weight", out_weight, e_wt);
      end
`ifdef SYNAPSE_SAT_EN
      chk("model_sat_seen", sat_seen, e_sat);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = 1'b0; stdp_valid = 1'b0; cfg_valid = 1'b0; kill = 1'b0;
  endtask

  task automatic cfg(input int idx, input int tag, input int w);
    cfg_valid = 1'b1; cfg_idx = IDX_W'(idx); cfg_tag = NEURON_W'(tag); cfg_weight = WEIGHT_W'(w);
    tick(); idle();
  endtask

  task automatic lookup(input int key);
    rd_valid = 1'b1; rd_neuron = NEURON_W'(key);
    tick(); idle();
  endtask

  task automatic stdp(input int key, input int d);
    stdp_valid = 1'b1; stdp_neuron = NEURON_W'(key); stdp_delta = DELTA_W'(d);
    tick(); idle();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd_ready", rd_ready, 1);
    chk("reset_out_hit", out_hit, 0);
    chk("reset_out_weight", out_weight, 0);
    chk("reset_stdp_miss", stdp_miss, 0);

    cfg(3, 'h12, 'h40);
    cfg(5, 'h20, 'h10);
    cfg(7, 'h30, 'hFD);
    cfg(8, 'h31, 'h02);

    lookup('h12);
    chk("hit_valid", out_valid, 1);
    chk("hit_flag", out_hit, 1);
    chk("hit_weight", out_weight, 'h40);
    lookup('h13);
    chk("miss_flag", out_hit, 0);
    chk("miss_weight", out_weight, 0);
    tick();
    chk("drain_valid", out_valid, 0);

    // Backpressure: second request must stall until out_ready returns.
    out_ready = 1'b0;
    lookup('h12);
    rd_valid = 1'b1; rd_neuron = 'h13;
    #1 chk("stall_rd_ready", rd_ready, 0);
    tick();
    chk("stall_hold_hit", out_hit, 1);
    chk("stall_hold_weight", out_weight, 'h40);
    out_ready = 1'b1;
    #1 chk("release_rd_ready", rd_ready, 1);
    tick(); idle();
    chk("release_resp_valid", out_valid, 1);
    chk("release_resp_hit", out_hit, 0);
    tick();

    // Lookup and STDP on one neuron in the same cycle sees the old weight.
    rd_valid = 1'b1; rd_neuron = 'h12;
    stdp_valid = 1'b1; stdp_neuron = 'h12; stdp_delta = 4'h1;
    tick(); idle();
    chk("same_cycle_old", out_weight, 'h40);
    lookup('h12);
    chk("same_cycle_new", out_weight, 'h41);

    stdp('h55, 1);
    chk("absent_miss_pulse", stdp_miss, 1);
    tick();
    chk("absent_miss_clear", stdp_miss, 0);

    stdp('h30, 5);
    lookup('h30);
`ifdef SYNAPSE_SAT_EN
    chk("sat_high", out_weight, 'hFF);
    chk("sat_seen_set", sat_seen, 1);
`else
    chk("wrap_high", out_weight, 'h02);
`endif
    stdp('h31, 'hC);
    lookup('h31);
`ifdef SYNAPSE_SAT_EN
    chk("sat_low", out_weight, 'h00);
`else
    chk("wrap_low", out_weight, 'hFE);
`endif

    stdp_valid = 1'b1; stdp_neuron = 'h20; stdp_delta = 4'h3;
    tick(); tick(); idle();
    lookup('h20);
    chk("accumulate", out_weight, 'h16);

    // cfg and STDP colliding on entry 5: cfg wins, STDP reported as discarded.
    cfg_valid = 1'b1; cfg_idx = 5; cfg_tag = 'h21; cfg_weight = 'h77;
    stdp_valid = 1'b1; stdp_neuron = 'h20; stdp_delta = 4'h1;
    tick(); idle();
    chk("collide_miss", stdp_miss, 1);
    lookup('h21);
    chk("collide_cfg_weight", out_weight, 'h77);
    lookup('h20);
    chk("collide_old_tag_gone", out_hit, 0);

    cfg(9, 'h12, 'h99);
    lookup('h12);
    chk("lowest_index_wins", out_weight, 'h41);

    // kill keeps a held response but empties the table.
    out_ready = 1'b0;
    lookup('h12);
    kill = 1'b1;
    tick(); idle();
    chk("kill_keeps_resp", out_valid, 1);
    chk("kill_keeps_weight", out_weight, 'h41);
`ifdef SYNAPSE_SAT_EN
    chk("kill_clears_sat", sat_seen, 0);
`endif
    out_ready = 1'b1;
    tick();
    lookup('h12);
    chk("kill_miss_a", out_hit, 0);
    lookup('h21);
    chk("kill_miss_b", out_hit, 0);
    cfg(3, 'h12, 'h40);
    kill = 1'b1; stdp_valid = 1'b1; stdp_neuron = 'h12; stdp_delta = 4'h1;
    tick(); idle();
    chk("kill_stdp_miss", stdp_miss, 1);

    // Reset with a response pending drops it.
    cfg(2, 'h05, 'h33);
    out_ready = 1'b0;
    lookup('h05);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("rst_drop_valid", out_valid, 0);
    chk("rst_rd_ready", rd_ready, 1);
    rst = 1'b0; out_ready = 1'b1;
    lookup('h05);
    chk("rst_table_cleared", out_hit, 0);

    for (int n = 0; n < 300; n++) begin
      kill        = ($urandom_range(0, 39) == 0);
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_idx     = IDX_W'($urandom_range(0, DEPTH - 1));
      cfg_tag     = NEURON_W'($urandom_range(16, 19));
      cfg_weight  = WEIGHT_W'($urandom);
      rd_valid    = ($urandom_range(0, 2) != 0);
      rd_neuron   = NEURON_W'($urandom_range(16, 20));
      out_ready   = ($urandom_range(0, 3) != 0);
      stdp_valid  = ($urandom_range(0, 1) != 0);
      stdp_neuron = NEURON_W'($urandom_range(16, 20));
      stdp_delta  = DELTA_W'($urandom);
      tick();
    end
    idle();
    out_ready = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
